// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: FSM states, move directions
// and the BCD digit width used by the score display path.
package snake_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t o;
        case (d)
            DIR_UP:   o = DIR_DOWN;
            DIR_DOWN: o = DIR_UP;
            DIR_LEFT: o = DIR_RIGHT;
            default:  o = DIR_LEFT;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Button/event inputs and display/step outputs of the game sequencer.
// There is no backpressure: step, frame_tick, hit and prey_hit are one-cycle
// strobes that are valid in the cycle they are high and are never stalled.
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic              start;
    logic              h;
    logic              u;
    logic              d;
    logic              l;
    logic              r;
    logic              frame_tick;
    logic              hit;
    logic              prey_hit;
    logic [1:0]        state;
    logic [1:0]        dir;
    logic              step;
    logic [BCD_W-1:0]  score_tens;
    logic [BCD_W-1:0]  score_ones;
    logic [3:0]        period;
    logic              game_over;

    modport master (
        output start, h, u, d, l, r, frame_tick, hit, prey_hit,
        input  state, dir, step, score_tens, score_ones, period, game_over
    );

    modport slave (
        input  start, h, u, d, l, r, frame_tick, hit, prey_hit,
        output state, dir, step, score_tens, score_ones, period, game_over
    );

endinterface

// File: rtl/snake_score_bcd.sv
// Two-digit BCD score counter that saturates at 99; clr restarts it at 00.
module snake_score_bcd
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic at_max;
    assign at_max = (tens == BCD_W'(9)) && (ones == BCD_W'(9));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc && !at_max) begin
            if (ones == BCD_W'(9)) begin
                ones <= '0;
                tens <= tens + BCD_W'(1);
            end else begin
                ones <= ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: start/pause/over FSM, frame-rate step gating, direction
// latch, speed level and score sequencing for the VGA snake.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int PERIOD_INIT   = 8,
    parameter int PERIOD_MIN    = 2,
    parameter int SPEEDUP_EVERY = 5
) (
    input  logic             clk,
    input  logic             reset,
    snake_game_ctrl_if.slave bus
);

    localparam logic [3:0] P_INIT    = 4'(PERIOD_INIT);
    localparam logic [3:0] P_MIN     = 4'(PERIOD_MIN);
    localparam logic [3:0] PREY_LAST = 4'(SPEEDUP_EVERY - 1);

    state_t     state_r;
    dir_t       dir_r;
    dir_t       pend_r;
    dir_t       pend_nxt;
    dir_t       req;
    logic       req_v;
    logic [3:0] fcnt;
    logic [3:0] prey_cnt;
    logic [3:0] period_r;
    logic       step_r;
    logic       over_r;
    logic       start_q;
    logic       h_q;
    logic       start_arm;
    logic       h_arm;
    logic       start_e;
    logic       h_e;
    logic       tick_done;
    logic       score_clr;
    logic       score_inc;

    // The arm flags keep a button held across reset release from producing an edge.
    assign start_e = bus.start & ~start_q & start_arm;
    assign h_e     = bus.h & ~h_q & h_arm;

    always_comb begin
        req   = DIR_RIGHT;
        req_v = 1'b0;
        if (bus.u) begin
            req   = DIR_UP;
            req_v = 1'b1;
        end else if (bus.d) begin
            req   = DIR_DOWN;
            req_v = 1'b1;
        end else if (bus.l) begin
            req   = DIR_LEFT;
            req_v = 1'b1;
        end else if (bus.r) begin
            req   = DIR_RIGHT;
            req_v = 1'b1;
        end
    end

    assign pend_nxt  = (req_v && (req != dir_opposite(dir_r))) ? req : pend_r;
    // >= rather than == so a speed-up that lands below the held count still steps.
    assign tick_done = bus.frame_tick && (fcnt >= (period_r - 4'd1));
    assign score_clr = (state_r == S_IDLE) && start_e;
    assign score_inc = (state_r == S_PLAY) && bus.prey_hit && !bus.hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            dir_r     <= DIR_RIGHT;
            pend_r    <= DIR_RIGHT;
            fcnt      <= '0;
            prey_cnt  <= '0;
            period_r  <= P_INIT;
            step_r    <= 1'b0;
            over_r    <= 1'b0;
            start_q   <= 1'b0;
            h_q       <= 1'b0;
            start_arm <= 1'b0;
            h_arm     <= 1'b0;
        end else begin
            start_q   <= bus.start;
            h_q       <= bus.h;
            start_arm <= start_arm | ~bus.start;
            h_arm     <= h_arm | ~bus.h;
            step_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_e) begin
                        state_r  <= S_PLAY;
                        dir_r    <= DIR_RIGHT;
                        pend_r   <= DIR_RIGHT;
                        fcnt     <= '0;
                        prey_cnt <= '0;
                        period_r <= P_INIT;
                    end
                end
                S_PLAY: begin
                    if (bus.hit) begin
                        state_r <= S_OVER;
                        over_r  <= 1'b1;
                    end else begin
                        pend_r <= pend_nxt;
                        if (tick_done) begin
                            step_r <= 1'b1;
                            fcnt   <= '0;
                            dir_r  <= pend_nxt;
                        end else if (bus.frame_tick) begin
                            fcnt <= fcnt + 4'd1;
                        end
                        if (bus.prey_hit) begin
                            if (prey_cnt == PREY_LAST) begin
                                prey_cnt <= '0;
                                if (period_r > P_MIN) period_r <= period_r - 4'd1;
                            end else begin
                                prey_cnt <= prey_cnt + 4'd1;
                            end
                        end
                        if (h_e) state_r <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (h_e) state_r <= S_PLAY;
                end
                default: begin
                    if (start_e) begin
                        state_r <= S_IDLE;
                        over_r  <= 1'b0;
                    end
                end
            endcase
        end
    end

    snake_score_bcd u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .tens  (bus.score_tens),
        .ones  (bus.score_ones)
    );

    assign bus.state     = state_r;
    assign bus.dir       = dir_r;
    assign bus.step      = step_r;
    assign bus.period    = period_r;
    assign bus.game_over = over_r;

endmodule
